// File: rtl/readout_fifo.sv
// readout_fifo: synchronous pointer-managed FIFO for event readout.
// The front-end pushes words in arrival order, and the readout side pops them in the same order.
// Status flags are registered: count, empty, full and almost_full.
// Sticky error flags: overflow and underflow.
//
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   clr            : synchronous flush of contents and flags; wins over we/rd
//   we, wdata      : write request and data
//   rd             : read (pop) request
//   oe             : output enable for rdata (READOUT_TRISTATE_EN only)
//   rdata, rvalid  : registered read data, one-cycle valid pulse per accepted pop
//   empty, full, almost_full, count : occupancy status
//   overflow, underflow             : sticky error flags
//
// Optional build macro: READOUT_TRISTATE_EN makes rdata tri-state under control of oe.
module readout_fifo #(
    parameter int unsigned DATBITS   = 24,
    parameter int unsigned ADDBITS   = 8,
    parameter int unsigned AFULL_LVL = 2**ADDBITS - 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [DATBITS-1:0] wdata,
    output logic               full,
    output logic               almost_full,
    input  logic               rd,
    input  logic               oe,
    output logic [DATBITS-1:0] rdata,
    output logic               rvalid,
    output logic               empty,
    output logic [ADDBITS:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned DEPTH   = 2**ADDBITS;
    localparam int unsigned CNTBITS = ADDBITS + 1;

    logic [DATBITS-1:0] mem [DEPTH];
    logic [ADDBITS-1:0] wptr;
    logic [ADDBITS-1:0] rptr;
    logic [DATBITS-1:0] rdata_q;

    logic               wr_ok_c;
    logic               rd_ok_c;
    logic [CNTBITS-1:0] count_nxt_c;

    // Acceptance uses the registered (pre-edge) flags.
    always_comb begin
        wr_ok_c     = we && !full;
        rd_ok_c     = rd && !empty;
        count_nxt_c = count;
        case ({wr_ok_c, rd_ok_c})
            2'b10:   count_nxt_c = count + CNTBITS'(1);
            2'b01:   count_nxt_c = count - CNTBITS'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Storage array; never reset, and writes are suppressed during clr and rst.
    always_ff @(posedge clk) begin
        if (wr_ok_c && !clr && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers, occupancy, read data and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rvalid      <= 1'b0;
            rdata_q     <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (clr) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rvalid      <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wptr <= wptr + ADDBITS'(1);
            end
            if (rd_ok_c) begin
                rptr    <= rptr + ADDBITS'(1);
                rdata_q <= mem[rptr];
            end
            rvalid      <= rd_ok_c;
            count       <= count_nxt_c;
            empty       <= (count_nxt_c == '0);
            full        <= (count_nxt_c == CNTBITS'(DEPTH));
            almost_full <= (count_nxt_c >= CNTBITS'(AFULL_LVL));
            if (we && full) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef READOUT_TRISTATE_EN
    // Release the shared readout bus when this FIFO is not selected.
    assign rdata = oe ? rdata_q : {DATBITS{1'bz}};
`else
    logic unused_oe;
    assign unused_oe = oe;
    assign rdata     = rdata_q;
`endif

endmodule

// File: tb/tb_readout_fifo.sv
// tb_readout_fifo: directed, table-driven bench for readout_fifo (default parameters).
module tb_readout_fifo;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 8;
    localparam int unsigned NV = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          oe;
    wire  [DW-1:0] rdata;
    logic          full;
    logic          almost_full;
    logic          rvalid;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int tests  = 0;
    int failed = 0;

    readout_fifo dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .wdata(wdata),
        .full(full), .almost_full(almost_full), .rd(rd), .oe(oe),
        .rdata(rdata), .rvalid(rvalid), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic          rd;
        logic          clr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          rvalid;
        logic [AW:0]   count;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t          vecs [NV];
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_d;
    logic [31:0]   zval;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given request inputs; returns #1 after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        we = w; wdata = d; rd = r; clr = c;
        @(posedge clk);
        #1;
        we = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // we, rd, clr, wdata | rdata, rvalid, count, empty, full, ovf, unf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h000001, 24'h000000, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 24'h000002, 24'h000000, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 24'h000003, 24'h000000, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 24'h000004, 24'h000000, 1'b0, 9'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 24'h000005, 24'h000000, 1'b0, 9'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000001, 1'b1, 9'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000002, 1'b1, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000003, 1'b1, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000004, 1'b1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000005, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000005, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000005, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 24'h000077, 24'h000005, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 24'h000099, 24'h000005, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 24'h000088, 24'h000005, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000088, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; clr = 1'b0; we = 1'b0; rd = 1'b0; oe = 1'b1; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset almost_full", 32'(almost_full), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset underflow", 32'(underflow), 32'd0);

        // Table: ordered push/pop, empty read, simultaneous ops when empty, clr priority
        for (int i = 0; i < int'(NV); i++) begin
            cyc(vecs[i].we, vecs[i].wdata, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
            chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].count));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
        end

        // Fill to full, watching almost_full and full thresholds
        cyc(1'b0, '0, 1'b0, 1'b1);
        q.delete();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0);
            q.push_back(24'h100000 + 24'(i));
            chk($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d almost_full", i), 32'(almost_full), 32'((i + 1) >= 252));
            chk($sformatf("fill%0d full", i), 32'(full), 32'((i + 1) == 256));
        end

        // Write while full is dropped and flagged
        cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        chk("ovf write overflow", 32'(overflow), 32'd1);
        chk("ovf write count", 32'(count), 32'd256);
        chk("ovf write full", 32'(full), 32'd1);

        // Push and pop together while full: pop wins, push dropped
        exp_d = q.pop_front();
        cyc(1'b1, 24'h555555, 1'b1, 1'b0);
        chk("full we+rd rdata", 32'(rdata), 32'(exp_d));
        chk("full we+rd rvalid", 32'(rvalid), 32'd1);
        chk("full we+rd count", 32'(count), 32'd255);
        chk("full we+rd full", 32'(full), 32'd0);
        chk("full we+rd overflow", 32'(overflow), 32'd1);

        for (int i = 0; i < 200; i++) begin
            exp_d = q.pop_front();
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("pop%0d rdata", i), 32'(rdata), 32'(exp_d));
            chk($sformatf("pop%0d rvalid", i), 32'(rvalid), 32'd1);
        end
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 24'h200000 + 24'(i), 1'b0, 1'b0);
            q.push_back(24'h200000 + 24'(i));
        end
        chk("wrap count", 32'(count), 32'd155);
        for (int i = 0; i < 155; i++) begin
            exp_d = q.pop_front();
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("drain%0d rdata", i), 32'(rdata), 32'(exp_d));
        end
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain count", 32'(count), 32'd0);
        chk("drain underflow", 32'(underflow), 32'd0);

        // Asynchronous reset mid-burst
        cyc(1'b1, 24'h111111, 1'b0, 1'b0);
        cyc(1'b1, 24'h222222, 1'b0, 1'b0);
        we = 1'b1; wdata = 24'h333333; rd = 1'b1;
        @(posedge clk);
        #1;
        chk("burst rdata", 32'(rdata), 32'h111111);
        #1 rst = 1'b1;
        #1;
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst empty", 32'(empty), 32'd1);
        chk("async rst rvalid", 32'(rvalid), 32'd0);
        chk("async rst rdata", 32'(rdata), 32'd0);
        chk("async rst overflow", 32'(overflow), 32'd1 - 32'd1);
        we = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 24'h3C3C3C, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("post rst first word", 32'(rdata), 32'h3C3C3C);
        chk("post rst count", 32'(count), 32'd0);

        // Output enable
        cyc(1'b1, 24'h123456, 1'b0, 1'b0);
        oe = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef READOUT_TRISTATE_EN
        zval = {8'h00, {DW{1'bz}}};
        chk("oe=0 rdata", 32'(rdata), zval);
`else
        chk("oe ignored rdata", 32'(rdata), 32'h123456);
`endif
        oe = 1'b1;
        #1;
        chk("oe=1 rdata", 32'(rdata), 32'h123456);
        chk("oe rvalid", 32'(rvalid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
